// File: rtl/onehot_scan_if.sv
// Handshake bundle for onehot_scan_decoder: control inputs plus Y/IDX/WRAP outputs.
interface onehot_scan_if #(parameter int N = 3);
    logic               EN;
    logic               LOAD;
    logic [N-1:0]       I;
    logic               STEP;
    logic               DIR;
    logic               AUTO;
    logic [(1<<N)-1:0]  Y;
    logic [N-1:0]       IDX;
    logic               WRAP;

    modport master (output EN, LOAD, I, STEP, DIR, AUTO, input Y, IDX, WRAP);
    modport slave  (input EN, LOAD, I, STEP, DIR, AUTO, output Y, IDX, WRAP);
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with loadable/steppable wrapping index.
// Optional auto-scan prescaler is built only when ONEHOT_SCAN_AUTO_EN is defined.
module onehot_scan_decoder #(
    parameter int N      = 3,
    parameter int PERIOD = 4
) (
    input logic          CLK,
    input logic          RST,
    onehot_scan_if.slave bus
);
    localparam int W = 1 << N;

    logic [N-1:0] idx, idx_nxt;
    logic         wrap, wrap_nxt;
    logic         tick;
    logic         step_take;

    if (PERIOD < 1) begin : g_period_invalid
    end

`ifdef ONEHOT_SCAN_AUTO_EN
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [PW-1:0] cnt, cnt_nxt;

    // LOAD, a dropped AUTO and the terminal count all restart the phase.
    always_comb begin
        tick    = bus.AUTO && !bus.LOAD && (cnt == PW'(PERIOD - 1));
        cnt_nxt = cnt + PW'(1);
        if (bus.LOAD || !bus.AUTO || tick)
            cnt_nxt = '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (bus.EN)
            cnt <= cnt_nxt;
    end
`else
    assign tick = 1'b0;
`endif

    // A manual step coinciding with an auto tick still moves only once.
    assign step_take = bus.STEP | tick;

    always_comb begin
        idx_nxt  = idx;
        wrap_nxt = 1'b0;
        if (bus.LOAD) begin
            idx_nxt = bus.I;
        end else if (step_take) begin
            if (bus.DIR) begin
                idx_nxt  = idx - N'(1);
                wrap_nxt = (idx == '0);
            end else begin
                idx_nxt  = idx + N'(1);
                wrap_nxt = (idx == '1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx  <= '0;
            wrap <= 1'b0;
        end else if (bus.EN) begin
            idx  <= idx_nxt;
            wrap <= wrap_nxt;
        end
    end

    for (genvar k = 0; k < W; k++) begin : g_lane
        assign bus.Y[k] = bus.EN && (idx == N'(k));
    end

    assign bus.IDX  = idx;
    assign bus.WRAP = wrap;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed table-driven bench for onehot_scan_decoder (N=3, PERIOD=4), plus auto-scan and reset sequences.
module tb_onehot_scan_decoder;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    onehot_scan_if #(.N(3)) bus ();

    onehot_scan_decoder #(.N(3), .PERIOD(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic       en, load, step, dir;
        logic [2:0] i;
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic en, logic load, logic [2:0] i, logic step, logic dir,
                                logic [7:0] y, logic [2:0] idx, logic wrap);
        vec_t v;
        v.en = en; v.load = load; v.i = i; v.step = step; v.dir = dir;
        v.y = y; v.idx = idx; v.wrap = wrap;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] y, input logic [2:0] idx, input logic wrap);
        check({tag, ".Y"},    bus.Y,           y);
        check({tag, ".IDX"},  {5'd0, bus.IDX}, {5'd0, idx});
        check({tag, ".WRAP"}, {7'd0, bus.WRAP}, {7'd0, wrap});
    endtask

    task automatic drive(input logic en, input logic load, input logic [2:0] i, input logic step,
                         input logic dir, input logic auto_r);
        bus.EN = en; bus.LOAD = load; bus.I = i; bus.STEP = step; bus.DIR = dir; bus.AUTO = auto_r;
    endtask

    // Apply inputs at negedge, let one rising edge pass, then sample 1 time unit later.
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //        en load i  step dir  y      idx wrap
        tbl[0]  = mk(1, 1, 5, 0, 0, 8'h20, 5, 0);
        tbl[1]  = mk(1, 1, 2, 1, 0, 8'h04, 2, 0);
        tbl[2]  = mk(1, 1, 7, 0, 0, 8'h80, 7, 0);
        tbl[3]  = mk(1, 0, 0, 1, 0, 8'h01, 0, 1);
        tbl[4]  = mk(1, 0, 0, 1, 1, 8'h80, 7, 1);
        tbl[5]  = mk(1, 0, 0, 1, 1, 8'h40, 6, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 8'h40, 6, 0);
        tbl[7]  = mk(1, 1, 3, 0, 0, 8'h08, 3, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 8'h00, 3, 0);
        tbl[9]  = mk(0, 1, 6, 1, 0, 8'h00, 3, 0);
        tbl[10] = mk(0, 0, 0, 1, 1, 8'h00, 3, 0);
        tbl[11] = mk(0, 0, 0, 1, 0, 8'h00, 3, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 8'h08, 3, 0);
        tbl[13] = mk(1, 0, 0, 1, 0, 8'h10, 4, 0);
        tbl[14] = mk(1, 1, 4, 0, 0, 8'h10, 4, 0);
        tbl[15] = mk(1, 1, 7, 0, 0, 8'h80, 7, 0);
        tbl[16] = mk(1, 0, 0, 1, 0, 8'h01, 0, 1);
        tbl[17] = mk(0, 0, 0, 1, 0, 8'h00, 0, 1);
        tbl[18] = mk(1, 0, 0, 0, 0, 8'h01, 0, 0);

        // Reset state with and without enable
        drive(1, 0, 0, 0, 0, 0);
        #3;
        check_state("rst_en1", 8'h01, 0, 0);
        bus.EN = 1'b0;
        #1;
        check_state("rst_en0", 8'h00, 0, 0);

        @(negedge CLK);
        RST = 1'b0;

        for (int v = 0; v < 19; v++) begin
            @(negedge CLK);
            drive(tbl[v].en, tbl[v].load, tbl[v].i, tbl[v].step, tbl[v].dir, 1'b0);
            cycle();
            check_state($sformatf("vec%0d", v), tbl[v].y, tbl[v].idx, tbl[v].wrap);
        end

        // EN gates Y combinationally between edges
        @(negedge CLK);
        drive(1, 1, 2, 0, 0, 0);
        cycle();
        bus.EN = 1'b0;
        #1;
        check("en_gate_off.Y", bus.Y, 8'h00);
        bus.EN = 1'b1;
        #1;
        check("en_gate_on.Y", bus.Y, 8'h04);

        // Auto scan from idx 0: one step per 4 cycles, WRAP after 8 steps
        @(negedge CLK);
        drive(1, 1, 0, 0, 0, 0);
        cycle();
        for (int k = 1; k <= 33; k++) begin
            @(negedge CLK);
            drive(1, 0, 0, 0, 0, 1);
            cycle();
`ifdef ONEHOT_SCAN_AUTO_EN
            check_state($sformatf("auto%0d", k), 8'(1 << ((k / 4) % 8)), 3'((k / 4) % 8),
                        (k == 32));
`else
            check_state($sformatf("auto%0d", k), 8'h01, 0, 0);
`endif
        end

        // AUTO dropped for one cycle restarts the prescaler phase
        @(negedge CLK);
        drive(1, 1, 0, 0, 0, 0);
        cycle();
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            drive(1, 0, 0, 0, 0, (k != 3));
            cycle();
`ifdef ONEHOT_SCAN_AUTO_EN
            check_state($sformatf("auto_clr%0d", k), (k == 7) ? 8'h02 : 8'h01, (k == 7) ? 3'd1 : 3'd0, 0);
`else
            check_state($sformatf("auto_clr%0d", k), 8'h01, 0, 0);
`endif
        end

        // STEP held with AUTO: exactly one step per cycle, including tick cycles
        @(negedge CLK);
        drive(1, 1, 0, 0, 0, 0);
        cycle();
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            drive(1, 0, 0, 1, 0, 1);
            cycle();
            check_state($sformatf("auto_step%0d", k), 8'(1 << (k % 8)), 3'(k % 8), (k == 8));
        end

        // Async reset mid-scan at idx 6, then the phase restarts from 0
        @(negedge CLK);
        drive(1, 1, 0, 0, 0, 0);
        cycle();
`ifdef ONEHOT_SCAN_AUTO_EN
        for (int k = 1; k <= 25; k++) begin
            @(negedge CLK);
            drive(1, 0, 0, 0, 0, 1);
            cycle();
        end
`else
        @(negedge CLK);
        drive(1, 1, 5, 0, 0, 0);
        cycle();
        @(negedge CLK);
        drive(1, 0, 0, 1, 0, 1);
        cycle();
`endif
        check("pre_rst.IDX", {5'd0, bus.IDX}, 8'd6);
        @(negedge CLK);
        drive(1, 0, 0, 0, 0, 1);
        #2;
        RST = 1'b1;
        #1;
        check_state("mid_rst", 8'h01, 0, 0);
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
`ifdef ONEHOT_SCAN_AUTO_EN
            check_state($sformatf("post_rst%0d", k), (k == 4) ? 8'h02 : 8'h01, (k == 4) ? 3'd1 : 3'd0, 0);
`else
            check_state($sformatf("post_rst%0d", k), 8'h01, 0, 0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Registered, parametrised binary-to-one-hot decoder with a stateful index. It can be loaded from a binary select, stepped up or down with wrap-around, and, optionally, auto-scanned at a programmable rate. It is the successor to the fixed 3-to-8 combinational decoder and drives row/column strobes, channel enables and multiplexed-display digit selects that need a walking one-hot pattern.

## Interface
- N, default 3: select width; output width is 2**N (N = 1..6).
- PERIOD, default 4: auto-scan step interval in clock cycles (≥ 1); used only when ONEHOT_SCAN_AUTO_EN is defined.
- CLK  input  1  rising-edge clock, the only clock.
- RST  input  1  reset, asynchronous and active-high.
- EN  input  1  enable; low freezes all state and forces Y to zero.
- LOAD  input  1  load index from I this cycle.
- I  input  N  binary select loaded on LOAD.
- STEP  input  1  advance index by one this cycle.
- DIR  input  1  step direction: 0 = up (+1), 1 = down (−1).
- AUTO  input  1  auto-scan request; ignored without ONEHOT_SCAN_AUTO_EN.
- Y  output  2**N  one-hot output; Y[k] = 1 iff the index equals k and EN = 1.
- IDX  output  N  current registered index.
- WRAP  output  1  one-cycle pulse: the previous cycle's step wrapped.

## Operation
- State: index register idx[N-1:0], WRAP register, and the prescaler counter (macro only).
- Y = EN ? (1 << idx) : 0. This is a combinational gate on registered state. No other output path is combinational.
- Per rising edge with EN = 1, in priority order:
  - LOAD = 1: idx ← I. WRAP ← 0. Prescaler ← 0. STEP and AUTO are ignored.
  - Otherwise, if a step is taken (STEP = 1, or an auto tick): idx ← idx ± 1 modulo 2**N, per DIR.
    - WRAP ← 1 when the step is up from 2**N−1 to 0, or down from 0 to 2**N−1. Otherwise WRAP ← 0.
  - Otherwise: idx holds and WRAP ← 0.
- A manual STEP and an auto tick in the same cycle produce exactly one step.
- EN = 0: idx, prescaler and WRAP hold their values. Y = 0. LOAD, STEP and AUTO are ignored.
- LOAD with I equal to the current idx is legal. It reloads the same value and still clears WRAP and the prescaler.
- Arithmetic is N-bit unsigned with natural wrap. There is no saturation.

## Timing
- RST asserted (asynchronously): idx = 0, WRAP = 0, prescaler = 0. Therefore Y = 1 if EN = 1, or 0 if EN = 0, and IDX = 0.
- Release of RST is synchronous to CLK. The first state update occurs on the first rising edge with RST low.
- Latency from LOAD, STEP, or an auto tick to the new Y/IDX: 1 cycle.
- WRAP asserts in the same cycle as the wrapped Y value and lasts exactly one cycle unless the next step wraps again. This is possible only with N = 1, or with consecutive steps in alternating directions across the boundary.
- Changes on EN appear on Y in the same cycle (combinational gate).
- RST mid-scan: the state returns to its reset values immediately. The prescaler phase is lost.

## Configuration
- ONEHOT_SCAN_AUTO_EN defined:
  - A ceil(log2(PERIOD))-bit prescaler counts while EN = 1, AUTO = 1 and LOAD = 0.
  - When the count is PERIOD−1, that cycle is an auto tick (step per DIR) and the prescaler returns to 0.
  - AUTO = 0 clears the prescaler.
  - PERIOD = 1 gives a step every cycle.
- ONEHOT_SCAN_AUTO_EN undefined: no prescaler is instantiated, AUTO is ignored, and only LOAD and STEP change idx.

## Test plan
- Reset and enable (N = 3):
  - RST = 1 with EN = 1 → Y = 8'h01, IDX = 0, WRAP = 0.
  - Drop EN → Y = 8'h00 while IDX stays 0.
- Load: EN = 1, LOAD = 1, I = 5 → next cycle Y = 8'h20, IDX = 5. LOAD = 1 with STEP = 1 and I = 2 → Y = 8'h04, with no step taken.
- Wrap up and down:
  - Load 7, then STEP with DIR = 0 → Y = 8'h01 with a single-cycle WRAP = 1.
  - STEP with DIR = 1 → Y = 8'h80 with WRAP = 1.
  - Further steps → WRAP = 0.
- Freeze: at IDX = 3, set EN = 0 and pulse STEP for 4 cycles → IDX stays 3 and Y = 0. Restore EN → Y = 8'h08.
- Auto scan (macro defined, PERIOD = 4):
  - AUTO = 1, DIR = 0 from IDX = 0 → IDX increments every 4th cycle and WRAP pulses after 8 steps.
  - With STEP held high as well → only one step per auto tick cycle.
  - Without the macro, the same stimulus with STEP = 0 → IDX stays 0.
- Async reset mid-scan: assert RST between clock edges at IDX = 6 → Y = 8'h01 immediately and the prescaler restarts from 0 after release.
